fc_topk_select: RTL

- Sits directly downstream of the FC classifier stage and consumes its serial logit stream (valid / class index / int8 logit).
- Keeps a running sorted top-K list with a one-cycle insertion per logit.
- On the FC end-of-layer pulse, emits the K winners in rank order over a valid/ready interface.
- Provides the final classification result (top-1 / top-5) to the host readout.

---
 rtl/fc_cls_pkg.sv | 33 +++
 rtl/fc_topk_select_if.sv | 29 ++
 rtl/fc_topk_slot.sv | 46 ++++
 rtl/fc_topk_select.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fc_cls_pkg.sv
// Shared types and defaults for the FC top-K selector.
//   DATA_W / IDX_W         : logit and class-index widths (fixed for the slice)
//   K_DEFAULT              : default number of ranked slots (1..8)
//   NUM_CLASSES_DEFAULT    : default logits per inference
//   fc_state_e             : IDLE / COLLECT / EMIT encoding
//   fc_slot_t              : one ranked-list record {valid, idx, logit}
package fc_cls_pkg;

    localparam int unsigned DATA_W              = 8;
    localparam int unsigned IDX_W               = 11;
    localparam int unsigned K_DEFAULT           = 5;
    localparam int unsigned NUM_CLASSES_DEFAULT = 1000;
    localparam int unsigned RANK_W              = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EMIT    = 2'd2
    } fc_state_e;

    typedef struct packed {
        logic              valid;
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] logit;
    } fc_slot_t;

    // Signed less-than on raw logit bit patterns.
    function automatic logic logit_lt(input logic [DATA_W-1:0] a,
                                      input logic [DATA_W-1:0] b);
        return $signed(a) < $signed(b);
    endfunction

endpackage

// File: rtl/fc_topk_select_if.sv
// Logit stream in / ranked stream out for the FC top-K selector.
//   in_valid, in_class_idx, in_logit, in_done : serial logits from the FC stage
//   out_valid, out_ready                      : ranked-entry handshake
//   out_rank, out_class_idx, out_logit        : ranked-entry payload
// master = producer/consumer side (FC stage + host), slave = selector side.
interface fc_topk_select_if;
    import fc_cls_pkg::*;

    logic              in_valid;
    logic [IDX_W-1:0]  in_class_idx;
    logic [DATA_W-1:0] in_logit;
    logic              in_done;
    logic              out_valid;
    logic              out_ready;
    logic [RANK_W-1:0] out_rank;
    logic [IDX_W-1:0]  out_class_idx;
    logic [DATA_W-1:0] out_logit;

    modport master (
        output in_valid, in_class_idx, in_logit, in_done, out_ready,
        input  out_valid, out_rank, out_class_idx, out_logit
    );

    modport slave (
        input  in_valid, in_class_idx, in_logit, in_done, out_ready,
        output out_valid, out_rank, out_class_idx, out_logit
    );

endinterface

// File: rtl/fc_topk_slot.sv
// One entry of the sorted top-K list.
//   clk, rst     : clock, synchronous active-high reset
//   clear        : invalidate the slot (new inference)
//   we           : a sample is being inserted this cycle
//   insert_here  : this slot is the insertion position
//   shift_in     : insertion is above this slot, take the upper neighbour
//   sample       : incoming sample record
//   upper        : upper neighbour's contents
//   slot         : current contents
//   beaten_c     : slot is invalid or its logit is strictly below the sample
module fc_topk_slot
    import fc_cls_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     clear,
    input  logic     we,
    input  logic     insert_here,
    input  logic     shift_in,
    input  fc_slot_t sample,
    input  fc_slot_t upper,
    output fc_slot_t slot,
    output logic     beaten_c
);

    fc_slot_t slot_q;

    // Slot storage: insert takes priority over shift.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            slot_q <= '0;
        end else if (we) begin
            if (insert_here) begin
                slot_q <= sample;
            end else if (shift_in) begin
                slot_q <= upper;
            end
        end
    end

    assign slot = slot_q;

    // Equal logits do not beat the slot, so earlier arrivals keep their rank.
    assign beaten_c = !slot_q.valid || logit_lt(slot_q.logit, sample.logit);

endmodule

// File: rtl/fc_topk_select.sv
// Running top-K selector behind the FC classifier stage.
//   clk, rst   : clock, synchronous active-high reset
//   start      : clear the list and begin collecting (honoured in IDLE only)
//   bus        : logit stream in, ranked stream out (fc_topk_select_if.slave)
//   busy       : state is COLLECT or EMIT
//   done       : one-cycle pulse after the last ranked entry is accepted
//   count_err  : sticky sample-count mismatch
// Optional build macro FC_TOPK_COUNT_CHECK_EN enables the sample counter
// behind count_err; without it count_err is tied low.
module fc_topk_select
    import fc_cls_pkg::*;
#(
    parameter int unsigned K           = K_DEFAULT,
    parameter int unsigned NUM_CLASSES = NUM_CLASSES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    fc_topk_select_if.slave      bus,
    output logic                 busy,
    output logic                 done,
    output logic                 count_err
);

    // Pointer is one bit wider than the rank so it can step past K-1.
    localparam int unsigned PTR_W = 4;

    if (K < 1 || K > 8 || NUM_CLASSES == 0) begin : g_bad_params
        $error("fc_topk_select: K must be 1..8 and NUM_CLASSES nonzero");
    end

    fc_state_e         state_q, state_d;
    fc_slot_t          slots  [K];
    fc_slot_t          uppers [K];
    fc_slot_t          sample;
    fc_slot_t          nxt_slot;
    logic [K-1:0]      beaten;
    logic [K-1:0]      insert_here;
    logic [K-1:0]      shift_in;
    logic              clear;
    logic              we;
    logic [PTR_W-1:0]  nxt;

    logic              out_valid_q, out_valid_d;
    logic [RANK_W-1:0] rank_q, rank_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] logit_q, logit_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    assign sample = '{valid: 1'b1, idx: bus.in_class_idx, logit: bus.in_logit};

    // Slot chain; each slot shifts from its upper neighbour.
    for (genvar i = 0; i < K; i++) begin : g_slot
        if (i == 0) begin : g_head
            assign uppers[i] = '0;
        end else begin : g_tail
            assign uppers[i] = slots[i-1];
        end

        fc_topk_slot u_slot (
            .clk         (clk),
            .rst         (rst),
            .clear       (clear),
            .we          (we),
            .insert_here (insert_here[i]),
            .shift_in    (shift_in[i]),
            .sample      (sample),
            .upper       (uppers[i]),
            .slot        (slots[i]),
            .beaten_c    (beaten[i])
        );
    end

    // First beaten slot is the insertion point; everything below it shifts.
    always_comb begin : p_prio
        logic seen;
        seen        = 1'b0;
        insert_here = '0;
        shift_in    = '0;
        for (int i = 0; i < K; i++) begin
            insert_here[i] = beaten[i] & ~seen;
            shift_in[i]    = seen;
            seen           = seen | beaten[i];
        end
    end

    // Entry to present next: slot 0 on entry to EMIT, else the one after the current rank.
    always_comb begin
        nxt      = out_valid_q ? PTR_W'(rank_q) + PTR_W'(1) : '0;
        nxt_slot = '0;
        for (int i = 0; i < K; i++) begin
            if (PTR_W'(i) == nxt) begin
                nxt_slot = slots[i];
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        rank_d      = rank_q;
        idx_d       = idx_q;
        logit_d     = logit_q;
        done_d      = 1'b0;
        clear       = 1'b0;
        we          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                out_valid_d = 1'b0;
                if (start) begin
                    state_d = ST_COLLECT;
                    clear   = 1'b1;
                end
            end
            ST_COLLECT: begin
                we = bus.in_valid;
                if (bus.in_done) begin
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                // Valid entries are packed at the top, so the first invalid one ends emission.
                if (!out_valid_q || bus.out_ready) begin
                    if (nxt_slot.valid) begin
                        out_valid_d = 1'b1;
                        rank_d      = RANK_W'(nxt);
                        idx_d       = nxt_slot.idx;
                        logit_d     = nxt_slot.logit;
                    end else begin
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            rank_q      <= '0;
            idx_q       <= '0;
            logit_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            rank_q      <= rank_d;
            idx_q       <= idx_d;
            logit_q     <= logit_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.out_rank      = rank_q;
    assign bus.out_class_idx = idx_q;
    assign bus.out_logit     = logit_q;
    assign busy              = busy_q;
    assign done              = done_q;

`ifdef FC_TOPK_COUNT_CHECK_EN
    localparam int unsigned CNT_W = IDX_W + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_total;
    logic             err_q, err_d;

    // Count includes a sample arriving in the same cycle as in_done.
    assign cnt_total = cnt_q + CNT_W'(bus.in_valid);

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_q == ST_IDLE && start) begin
            cnt_d = '0;
            err_d = 1'b0;
        end else if (state_q == ST_COLLECT) begin
            cnt_d = cnt_total;
            if (bus.in_done && (cnt_total != CNT_W'(NUM_CLASSES))) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign count_err = err_q;
`else
    assign count_err = 1'b0;
`endif

endmodule
